isa_prefetch_cache: RTL and testbench
=====================================

# isa_prefetch_cache

- Instruction-side prefetch window between the associative-processor fetch logic and the DDR3 interface top.
- On a fetch miss it requests one `ISA_DEPTH`-instruction burst from DDR, starting at the missing instruction. It captures the returned words into a local line RAM and serves fetches with 1-cycle hit latency.
- Fetches that hit already-arrived entries are served while the fill is still in progress (early restart).

## Interface
Parameters:
- `ISA_WIDTH`, 30, instruction width.
- `DDR_ADDR_WIDTH`, 28, DDR application address width.
- `ADDR_WIDTH_MEM`, 16, instruction index (PC) width.
- `ISA_DEPTH`, 72, window size in instructions; also the burst length.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock (DDR `ui_clk` domain).
- `rst` in 1: asynchronous, active-high reset.
- `fetch_req` in 1: fetch request; held high until `fetch_valid`.
- `fetch_addr` in `ADDR_WIDTH_MEM`: instruction index; stable while `fetch_req` is high.
- `flush` in 1: single-cycle pulse that invalidates the window.
- `fetch_valid` out 1: one-cycle pulse; `fetch_ins` is valid.
- `fetch_ins` out `ISA_WIDTH`: fetched instruction.
- `cache_busy` out 1: high when state ≠ IDLE.
- `ISA_read_req` out 1: DDR read request.
- `ISA_read_addr` out `DDR_ADDR_WIDTH`: DDR address = `fetch_addr << 3`, zero-extended.
- `isa_read_len` out 10: burst length in words.
- `ddr_rdy` in 1: DDR side accepts a request.
- `rd_burst_data_valid` in 1: a returned word is present this cycle.
- `rd_cnt_isa` in 10: index (0..len-1) of the returned word.
- `instruction_to_cache` in `ISA_WIDTH`: returned instruction.

## Operation
State machine:
- **IDLE**
  - Hit → serve the fetch.
  - Miss → latch `win_base = fetch_addr`, clear `fill_cnt`, `win_valid = 1`, go to REQ.
- **REQ**
  - Drive `ISA_read_req = 1`, `ISA_read_addr = {win_base, 3'b000}`, `isa_read_len = ISA_DEPTH`.
  - Request is accepted on the cycle `ISA_read_req && ddr_rdy`. Deassert next cycle, go to FILL.
  - With `ddr_rdy` low, hold the request indefinitely.
- **FILL**
  - Each `rd_burst_data_valid`: write `instruction_to_cache` to RAM[`rd_cnt_isa`], `fill_cnt++`.
  - `fill_cnt == ISA_DEPTH` → IDLE.
  - Beats with `rd_cnt_isa ≥ ISA_DEPTH`, and beats arriving in IDLE/REQ, are ignored.

Hit rule:
- `off = fetch_addr − win_base`, computed modulo 2^`ADDR_WIDTH_MEM` (unsigned).
- Hit iff `win_valid && off < fill_cnt`.
- A fetch below `win_base` wraps to a large `off` and is therefore a miss.

Miss handling during FILL:
- `off < ISA_DEPTH` (entry not yet arrived): wait; the fetch hits once the entry is written.
- `off ≥ ISA_DEPTH`: wait for FILL to complete, then re-evaluate in IDLE (this triggers a refill).

Flush:
- Clears `win_valid`.
- In FILL: drain and discard the remaining beats, then go to IDLE.
- In REQ: the request still completes and its data is drained.
- A pending fetch is re-evaluated after the drain.

Simultaneous events:
- A beat write and a hit read of the same entry in one cycle: the hit requires `off < fill_cnt` using the pre-increment count, so the read is served the next cycle.
- `flush` coinciding with a hit: the flush wins and no `fetch_valid` is issued.

Reset:
- Asynchronous; any state → IDLE.
- Clears `win_valid`, `fill_cnt`, `win_base`.
- All outputs 0: `fetch_valid`, `fetch_ins`, `cache_busy`, `ISA_read_req`, `ISA_read_addr`, `isa_read_len`.
- Reset mid-fill abandons the burst; the DDR side is reset by the same `rst`.

## Timing
- Hit latency: `fetch_req` sampled with hit at cycle N → `fetch_valid` and `fetch_ins` at N+1, from a registered RAM read.
- `fetch_valid` lasts 1 cycle. A `fetch_req` still high at N+1 is treated as a new request and re-evaluated.
- Miss → `ISA_read_req` rises the cycle after the miss is detected in IDLE.
- Miss penalty = 2 + DDR latency + (`rd_cnt_isa` of target + 1) cycles.
- `ISA_read_req` is high for exactly the REQ cycles, and is low the cycle after acceptance.
- `cache_busy` is registered and follows state with no extra delay.

## Structure
- Package `ap_isa_pkg`:
  - state enum {IDLE, REQ, FILL}.
  - `DDR_ADDR_SHIFT = 3`.
  - `ISA_LEN_W = 10`.
- Sub-module `isa_line_ram`:
  - Simple dual-port RAM, `ISA_DEPTH × ISA_WIDTH`.
  - One write port, one synchronous read port.
  - No reset on contents.
- The top level holds the FSM, `win_base`, `fill_cnt`, the hit comparator and the output registers.

## Test plan
- **Cold miss:** `fetch_addr = 0x0010` after reset.
  - `ISA_read_req` with addr `0x80` and len 72.
  - Hold `ddr_rdy` low 5 cycles: request stays high.
  - 72 beats of value `0x100+k` → `fetch_ins = 0x100`.
- **Hit:** after the fill, fetch `0x0015` → `fetch_valid` 1 cycle later with `0x105`, and no DDR request.
- **Early restart:** fetch `0x0012` during the fill, with beat 2 arriving at cycle T → `fetch_valid` at T+2; FILL continues to 72 beats.
- **Wrap miss:** window base `0x0010`, fetch `0x000F` → new request at addr `0x78`; fetch `0x0058` (off = 72) also misses.
- **Flush mid-fill:** flush after 10 beats → remaining 62 beats discarded, `cache_busy` stays high until the last beat, then a previously hitting fetch misses and refetches.
- **Reset mid-fill:** `rst` at beat 30 → all outputs 0 immediately; a subsequent fetch of the same address re-requests.

Source files
------------

// File: rtl/ap_isa_pkg.sv
// Shared types and constants for the instruction prefetch window.
package ap_isa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    // DDR addresses are 8 application units per instruction index.
    localparam int unsigned DDR_ADDR_SHIFT = 3;
    localparam int unsigned ISA_LEN_W      = 10;

endpackage

// File: rtl/isa_line_ram.sv
// Line storage for the prefetch window: one write port, one registered read port.
module isa_line_ram #(
    parameter int unsigned WIDTH  = 30,
    parameter int unsigned DEPTH  = 72,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; the output register clears so the fetch bus is 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/isa_prefetch_cache.sv
// Instruction prefetch window: one DDR burst per miss, early-restart hits during fill.
module isa_prefetch_cache
    import ap_isa_pkg::*;
#(
    parameter int unsigned ISA_WIDTH      = 30,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH_MEM = 16,
    parameter int unsigned ISA_DEPTH      = 72
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_req,
    input  logic [ADDR_WIDTH_MEM-1:0] fetch_addr,
    input  logic                      flush,
    output logic                      fetch_valid,
    output logic [ISA_WIDTH-1:0]      fetch_ins,
    output logic                      cache_busy,
    output logic                      ISA_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    output logic [ISA_LEN_W-1:0]      isa_read_len,
    input  logic                      ddr_rdy,
    input  logic                      rd_burst_data_valid,
    input  logic [ISA_LEN_W-1:0]      rd_cnt_isa,
    input  logic [ISA_WIDTH-1:0]      instruction_to_cache
);

    localparam int unsigned RAM_AW = $clog2(ISA_DEPTH);

    state_t                      state, state_d;
    logic [ADDR_WIDTH_MEM-1:0]   win_base, win_base_d;
    logic [ISA_LEN_W-1:0]        fill_cnt, fill_cnt_d;
    logic                        win_valid, win_valid_d;
    logic                        read_req_d;
    logic [DDR_ADDR_WIDTH-1:0]   read_addr_d;
    logic [ISA_LEN_W-1:0]        read_len_d;
    logic [ADDR_WIDTH_MEM-1:0]   off_c;
    logic                        hit_c;
    logic                        beat_ok_c;
    logic                        serve_c;
    logic                        ram_we_c;

    // Offset into the window wraps, so fetches below win_base land far out and miss.
    always_comb begin
        off_c     = fetch_addr - win_base;
        hit_c     = win_valid && (off_c < ADDR_WIDTH_MEM'(fill_cnt));
        beat_ok_c = rd_burst_data_valid && (rd_cnt_isa < ISA_LEN_W'(ISA_DEPTH));
        serve_c   = fetch_req && hit_c && !flush;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        win_base_d  = win_base;
        fill_cnt_d  = fill_cnt;
        win_valid_d = win_valid && !flush;
        read_req_d  = ISA_read_req;
        read_addr_d = ISA_read_addr;
        read_len_d  = isa_read_len;
        ram_we_c    = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req && !hit_c && !flush) begin
                    state_d     = REQ;
                    win_base_d  = fetch_addr;
                    fill_cnt_d  = '0;
                    win_valid_d = 1'b1;
                    read_req_d  = 1'b1;
                    read_addr_d = DDR_ADDR_WIDTH'(fetch_addr) << DDR_ADDR_SHIFT;
                    read_len_d  = ISA_LEN_W'(ISA_DEPTH);
                end
            end
            REQ: begin
                if (ddr_rdy) begin
                    state_d    = FILL;
                    read_req_d = 1'b0;
                end
            end
            FILL: begin
                // After a flush the remaining beats are counted but not stored.
                if (beat_ok_c) begin
                    ram_we_c   = win_valid && !flush;
                    fill_cnt_d = fill_cnt + ISA_LEN_W'(1);
                    if (fill_cnt == ISA_LEN_W'(ISA_DEPTH - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Window bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_base      <= '0;
            fill_cnt      <= '0;
            win_valid     <= 1'b0;
            fetch_valid   <= 1'b0;
            cache_busy    <= 1'b0;
            ISA_read_req  <= 1'b0;
            ISA_read_addr <= '0;
            isa_read_len  <= '0;
        end else begin
            win_base      <= win_base_d;
            fill_cnt      <= fill_cnt_d;
            win_valid     <= win_valid_d;
            fetch_valid   <= serve_c;
            cache_busy    <= (state_d != IDLE);
            ISA_read_req  <= read_req_d;
            ISA_read_addr <= read_addr_d;
            isa_read_len  <= read_len_d;
        end
    end

    // Line storage; the registered read data is the fetch bus.
    isa_line_ram #(
        .WIDTH  (ISA_WIDTH),
        .DEPTH  (ISA_DEPTH),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_c),
        .waddr (RAM_AW'(rd_cnt_isa)),
        .wdata (instruction_to_cache),
        .re    (serve_c),
        .raddr (RAM_AW'(off_c)),
        .rdata (fetch_ins)
    );

endmodule

// File: tb/tb_isa_prefetch_cache.sv
// Self-checking bench for isa_prefetch_cache with a behavioural DDR burst responder.
module tb_isa_prefetch_cache;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        flush;
    logic        fetch_valid;
    logic [29:0] fetch_ins;
    logic        cache_busy;
    logic        ISA_read_req;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;
    logic        ddr_rdy;
    logic        rd_burst_data_valid;
    logic [9:0]  rd_cnt_isa;
    logic [29:0] instruction_to_cache;

    isa_prefetch_cache #(
        .ISA_WIDTH(30), .DDR_ADDR_WIDTH(28), .ADDR_WIDTH_MEM(16), .ISA_DEPTH(72)
    ) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ins(fetch_ins), .cache_busy(cache_busy),
        .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
        .ddr_rdy(ddr_rdy), .rd_burst_data_valid(rd_burst_data_valid), .rd_cnt_isa(rd_cnt_isa),
        .instruction_to_cache(instruction_to_cache)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int valid_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [29:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (fetch_valid) valid_cnt <= valid_cnt + 1;

    // DDR contents: instruction at PC p is p + 0xF0.
    function automatic logic [29:0] ins_of(input logic [15:0] pc);
        return 30'(pc) + 30'h0F0;
    endfunction

    // DDR responder state (written only by the responder process).
    int          beat_gap = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    logic [9:0]  stray_idx = 10'd0;
    int          beats_sent = 0;
    int          beat2_cyc = 0;
    int          last_beat_cyc = 0;
    bit          m_active = 1'b0;
    bit          m_prev_req = 1'b0;
    int          m_k = 0;
    int          m_wait = 0;
    int          m_len = 0;
    logic [15:0] m_bpc = 16'd0;
    logic [27:0] m_cap_addr = 28'd0;
    logic [9:0]  m_cap_len = 10'd0;

    // Burst responder: starts a burst once an asserted request is seen to drop.
    initial begin
        rd_burst_data_valid  = 1'b0;
        rd_cnt_isa           = 10'd0;
        instruction_to_cache = 30'd0;
        forever begin
            @(negedge clk);
            rd_burst_data_valid = 1'b0;
            if (rst) begin
                m_active   = 1'b0;
                m_prev_req = 1'b0;
            end else begin
                if (stray_done != stray_req) begin
                    rd_burst_data_valid  = 1'b1;
                    rd_cnt_isa           = stray_idx;
                    instruction_to_cache = 30'h3FFF_FFFF;
                    stray_done           = stray_req;
                end else if (m_active) begin
                    if (m_wait > 0) begin
                        m_wait = m_wait - 1;
                    end else begin
                        rd_burst_data_valid  = 1'b1;
                        rd_cnt_isa           = 10'(m_k);
                        instruction_to_cache = ins_of(m_bpc + 16'(m_k));
                        if (m_k == 2) beat2_cyc = cyc;
                        m_k        = m_k + 1;
                        beats_sent = m_k;
                        if (m_k >= m_len) begin
                            m_active      = 1'b0;
                            last_beat_cyc = cyc;
                        end else begin
                            m_wait = beat_gap;
                        end
                    end
                end
                if (m_prev_req && !ISA_read_req) begin
                    m_active   = 1'b1;
                    m_k        = 0;
                    beats_sent = 0;
                    m_wait     = 2;
                    m_bpc      = 16'(m_cap_addr >> 3);
                    m_len      = int'(m_cap_len);
                end
                if (ISA_read_req) begin
                    m_cap_addr = ISA_read_addr;
                    m_cap_len  = isa_read_len;
                end
                m_prev_req = ISA_read_req;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
        check({tag, " fetch_ins"}, 32'(fetch_ins), 32'd0);
        check({tag, " cache_busy"}, 32'(cache_busy), 32'd0);
        check({tag, " read_req"}, 32'(ISA_read_req), 32'd0);
        check({tag, " read_addr"}, 32'(ISA_read_addr), 32'd0);
        check({tag, " read_len"}, 32'(isa_read_len), 32'd0);
    endtask

    task automatic start_fetch(input logic [15:0] a, input logic [29:0] e);
        exp_q.push_back(e);
        fetch_addr = a;
        fetch_req  = 1'b1;
    endtask

    task automatic finish_fetch(input string name, input int budget, output bit saw_req,
                                output logic [27:0] raddr, output logic [9:0] rlen, output int vcyc);
        logic [29:0] e;
        saw_req = 1'b0;
        raddr   = 28'd0;
        rlen    = 10'd0;
        vcyc    = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ISA_read_req && !saw_req) begin
                saw_req = 1'b1;
                raddr   = ISA_read_addr;
                rlen    = isa_read_len;
            end
            if (fetch_valid) begin
                vcyc = cyc;
                break;
            end
        end
        fetch_req = 1'b0;
        if (vcyc < 0) begin
            fail_now({name, " fetch_valid"});
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            fail_now({name, " scoreboard empty"});
        end else begin
            e = exp_q.pop_front();
            check({name, " ins"}, 32'(fetch_ins), 32'(e));
        end
    endtask

    task automatic do_fetch(input string name, input logic [15:0] a, input logic [29:0] e,
                            input bit miss, input logic [27:0] exp_addr);
        bit          saw;
        logic [27:0] ra;
        logic [9:0]  rl;
        int          vc;
        start_fetch(a, e);
        finish_fetch(name, 400, saw, ra, rl, vc);
        check({name, " miss"}, 32'(saw), 32'(miss));
        if (miss) begin
            check({name, " req_addr"}, 32'(ra), 32'(exp_addr));
            check({name, " req_len"}, 32'(rl), 32'd72);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!cache_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now({name, " idle"});
    endtask

    task automatic wait_beats(input string name, input int n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (beats_sent >= n) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now({name, " beats"});
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [29:0] ins;
        bit          miss;
        logic [27:0] raddr;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        bit          saw;
        logic [27:0] ra;
        logic [9:0]  rl;
        int          vc;
        int          hold_cnt;
        int          v0;

        // Window sequence starting from base 0x10 after the cold fill.
        vecs[0] = '{16'h0010, 30'h100, 1'b0, 28'h0};
        vecs[1] = '{16'h0015, 30'h105, 1'b0, 28'h0};
        vecs[2] = '{16'h0057, 30'h147, 1'b0, 28'h0};
        vecs[3] = '{16'h000F, 30'h0FF, 1'b1, 28'h78};
        vecs[4] = '{16'h0056, 30'h146, 1'b0, 28'h0};
        vecs[5] = '{16'h0057, 30'h147, 1'b1, 28'h2B8};
        vecs[6] = '{16'h0058, 30'h148, 1'b0, 28'h0};
        vecs[7] = '{16'h009E, 30'h18E, 1'b0, 28'h0};
        vecs[8] = '{16'h0010, 30'h100, 1'b1, 28'h80};
        vecs[9] = '{16'h0058, 30'h148, 1'b1, 28'h2C0};

        rst = 1'b1; fetch_req = 1'b0; fetch_addr = 16'd0; flush = 1'b0; ddr_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Cold miss with the DDR side stalling the request.
        ddr_rdy = 1'b0;
        start_fetch(16'h0010, 30'h100);
        @(negedge clk);
        check("cold read_req", 32'(ISA_read_req), 32'd1);
        check("cold read_addr", 32'(ISA_read_addr), 32'h80);
        check("cold read_len", 32'(isa_read_len), 32'd72);
        check("cold busy", 32'(cache_busy), 32'd1);
        hold_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ISA_read_req) hold_cnt++;
        end
        check("cold req_held", 32'(hold_cnt), 32'd5);
        ddr_rdy = 1'b1;
        @(negedge clk);
        check("cold req_drop", 32'(ISA_read_req), 32'd0);
        finish_fetch("cold", 200, saw, ra, rl, vc);
        wait_idle("cold", 200);
        check("cold beats", 32'(beats_sent), 32'd72);
        check("cold valid_count", 32'(valid_cnt), 32'd1);

        // Table-driven hits and misses.
        for (int i = 0; i < 10; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ins, vecs[i].miss, vecs[i].raddr);
        end
        wait_idle("table", 400);

        // Early restart: a fetch waiting on beat 2 is served two cycles after it arrives.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        beat_gap = 4;
        do_fetch("er_base", 16'h0010, 30'h100, 1'b1, 28'h80);
        start_fetch(16'h0012, 30'h102);
        finish_fetch("er_wait", 200, saw, ra, rl, vc);
        check("er miss", 32'(saw), 32'd0);
        check("er latency", 32'(vc - beat2_cyc), 32'd2);
        wait_idle("er", 600);
        check("er beats", 32'(beats_sent), 32'd72);
        beat_gap = 0;

        // A beat arriving while idle must not disturb the window.
        stray_idx = 10'd5;
        stray_req = stray_req + 1;
        repeat (3) @(negedge clk);
        do_fetch("stray", 16'h0015, 30'h105, 1'b0, 28'h0);

        // Flush after about ten beats: drain the rest, then the old window misses.
        do_fetch("ff_miss", 16'h0200, 30'h2F0, 1'b1, 28'h1000);
        wait_beats("ff", 10);
        v0 = valid_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("ff busy", 32'(cache_busy), 32'd1);
        wait_idle("ff", 200);
        check("ff busy_until_last", 32'(cyc - last_beat_cyc), 32'd1);
        check("ff beats", 32'(beats_sent), 32'd72);
        @(negedge clk);
        check("ff no_valid", 32'(valid_cnt), 32'(v0));
        do_fetch("ff_refetch", 16'h0201, 30'h2F1, 1'b1, 28'h1008);
        wait_idle("ff_refetch", 200);

        // Flush coinciding with a hit: no valid, then the fetch refills.
        start_fetch(16'h0205, 30'h2F5);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fh no_valid", 32'(fetch_valid), 32'd0);
        finish_fetch("fh", 200, saw, ra, rl, vc);
        check("fh miss", 32'(saw), 32'd1);
        check("fh req_addr", 32'(ra), 32'h1028);
        wait_idle("fh", 200);

        // Reset mid-fill clears outputs at once; the same address re-requests.
        do_fetch("rst_miss", 16'h0300, 30'h3F0, 1'b1, 28'h1800);
        wait_beats("rst", 30);
        check("rst busy_before", 32'(cache_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midfill");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_fetch("rst_refetch", 16'h0300, 30'h3F0, 1'b1, 28'h1800);
        wait_idle("rst_refetch", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
